// File: rtl/button_debounce.sv
// Button/switch conditioner: two-flop synchroniser, stable-count debounce FSM,
// registered level plus one-cycle rise/fall pulses, and a wrapping press counter.
module button_debounce #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_WIDTH     = 20,
  parameter int PCNT_WIDTH    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in,
  output logic                  out,
  output logic                  rise,
  output logic                  fall,
  output logic [PCNT_WIDTH-1:0] press_count
);

  typedef enum logic [1:0] {
    IDLE_LOW,
    WAIT_HIGH,
    IDLE_HIGH,
    WAIT_LOW
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

  logic                  sync1_q, sync1_d;
  logic                  sync2_q, sync2_d;
  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  out_q, out_d;
  logic                  rise_q, rise_d;
  logic                  fall_q, fall_d;
  logic [PCNT_WIDTH-1:0] pcnt_q, pcnt_d;

  // Synchroniser chain: only sync2 is ever looked at by the FSM.
  always_comb begin
    sync1_d = in;
    sync2_d = sync1_q;
  end

  // Debounce next-state, counter, level and pulse decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    pcnt_d  = pcnt_q;
    case (state_q)
      IDLE_LOW: begin
        if (sync2_q) begin
          state_d = WAIT_HIGH;
          cnt_d   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!sync2_q) begin
          state_d = IDLE_LOW;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HIGH;
          out_d   = 1'b1;
          rise_d  = 1'b1;
          pcnt_d  = pcnt_q + PCNT_WIDTH'(1);
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      IDLE_HIGH: begin
        if (!sync2_q) begin
          state_d = WAIT_LOW;
          cnt_d   = '0;
        end
      end
      WAIT_LOW: begin
        if (sync2_q) begin
          state_d = IDLE_HIGH;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LOW;
          out_d   = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_d = IDLE_LOW;
        cnt_d   = '0;
        out_d   = 1'b0;
      end
    endcase
  end

  // State register with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      pcnt_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      pcnt_q  <= pcnt_d;
    end
  end

  assign out         = out_q;
  assign rise        = rise_q;
  assign fall        = fall_q;
  assign press_count = pcnt_q;

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce: stimulus queues expected pulses
// (edge index, kind, press_count); a negedge monitor matches DUT pulses.
module tb_button_debounce;

  localparam int STABLE = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       in;
  logic       out;
  logic       rise;
  logic       fall;
  logic [7:0] press_count;

  button_debounce #(
    .STABLE_CYCLES(STABLE),
    .CNT_WIDTH(20),
    .PCNT_WIDTH(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in(in),
    .out(out),
    .rise(rise),
    .fall(fall),
    .press_count(press_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    bit is_rise;
    int pcnt;
  } ev_t;

  ev_t q[$];
  int  edge_n = 0;
  int  checks = 0;
  int  passes = 0;
  int  pcnt_m = 0;
  int  exp_rise = 0;
  int  exp_fall = 0;
  int  rise_seen = 0;
  int  fall_seen = 0;
  bit  done = 1'b0;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Level change: the new level is accepted STABLE+2 edges after the first
  // edge that samples it, i.e. at edge index edge_n + STABLE + 3.
  task automatic go_high(input int hold);
    ev_t e;
    in = 1'b1;
    pcnt_m = (pcnt_m + 1) % 256;
    e.cyc = edge_n + STABLE + 3;
    e.is_rise = 1'b1;
    e.pcnt = pcnt_m;
    q.push_back(e);
    exp_rise++;
    tick(hold);
  endtask

  task automatic go_low(input int hold);
    ev_t e;
    in = 1'b0;
    e.cyc = edge_n + STABLE + 3;
    e.is_rise = 1'b0;
    e.pcnt = pcnt_m;
    q.push_back(e);
    exp_fall++;
    tick(hold);
  endtask

  // Monitor: every pulse must match the head of the queue; overdue entries fail.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (!done) begin
        if (rise && fall) check("rise_fall_overlap", 1, 0);
        if (rise) rise_seen++;
        if (fall) fall_seen++;
        if (rise || fall) begin
          if (q.size() == 0) begin
            check("spurious_pulse", int'({rise, fall}), 0);
          end else begin
            e = q.pop_front();
            check("pulse_edge", edge_n, e.cyc);
            check("pulse_kind", int'(rise), int'(e.is_rise));
            check("pulse_out_level", int'(out), int'(e.is_rise));
            check("pulse_press_count", int'(press_count), e.pcnt);
          end
        end else if (q.size() > 0 && q[0].cyc < edge_n) begin
          check("missed_pulse_edge", edge_n, q[0].cyc);
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    in    = 1'b0;
    tick(3);
    check("reset_out", int'(out), 0);
    check("reset_rise", int'(rise), 0);
    check("reset_fall", int'(fall), 0);
    check("reset_press_count", int'(press_count), 0);
    reset = 1'b0;
    tick(2);

    // Bounce: no run of ones reaches the window.
    begin
      bit pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      foreach (pat[i]) begin
        in = pat[i];
        tick(1);
      end
      in = 1'b0;
      tick(12);
      check("bounce_out", int'(out), 0);
      check("bounce_press_count", int'(press_count), 0);
    end

    // Clean press then release.
    go_high(20);
    check("press_out", int'(out), 1);
    check("press_count_after_press", int'(press_count), 1);
    go_low(20);
    check("release_out", int'(out), 0);
    check("press_count_after_release", int'(press_count), 1);

    // Wrap: 256 press/release pairs from a cleared counter.
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    pcnt_m = 0;
    tick(2);
    for (int i = 0; i < 256; i++) begin
      go_high(9);
      if (i == 254) check("wrap_count_255", int'(press_count), 255);
      go_low(9);
    end
    check("wrap_count_0", int'(press_count), 0);

    // Reset in the middle of WAIT_HIGH while in stays high.
    in = 1'b1;
    tick(4);
    reset = 1'b1;
    tick(1);
    check("midwait_reset_out", int'(out), 0);
    check("midwait_reset_rise", int'(rise), 0);
    reset = 1'b0;
    pcnt_m = 0;
    go_high(12);
    check("midwait_out_after", int'(out), 1);
    go_low(12);

    // Reset held with in high: everything stays quiet, then one rise.
    in = 1'b1;
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("held_reset_outputs", int'({out, rise, fall, press_count}), 0);
    end
    reset = 1'b0;
    pcnt_m = 0;
    go_high(15);
    check("held_reset_press_count", int'(press_count), 1);

    tick(5);
    check("queue_drained", q.size(), 0);
    check("total_rise", rise_seen, exp_rise);
    check("total_fall", fall_seen, exp_fall);
    done = 1'b1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
